// File: rtl/beta_window.sv
// Backward (beta) state-metric unit for an 8-state max-log-MAP SISO decoder.
// Buffers a block of branch-metric pairs, then replays them last-to-first through the beta recursion.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no block in flight; first valid_branch writes entry 0
// FILL  | collecting branch pairs into the buffer
// RUN   | popping entries count-1 .. 0, one beta step per cycle
module beta_window #(
    parameter int K_MAX = 64,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   fsm_state,
    input  logic         valid_branch,
    input  logic         last_branch,
    input  logic [W-1:0] init_branch1,
    input  logic [W-1:0] init_branch2,
    output logic [W-1:0] beta_0,
    output logic [W-1:0] beta_1,
    output logic [W-1:0] beta_2,
    output logic [W-1:0] beta_3,
    output logic [W-1:0] beta_4,
    output logic [W-1:0] beta_5,
    output logic [W-1:0] beta_6,
    output logic [W-1:0] beta_7,
    output logic [W-1:0] branch1_out,
    output logic [W-1:0] branch2_out,
    output logic         valid_beta,
    output logic         last_beta,
    output logic         busy
);

    localparam int AW = $clog2(K_MAX);
    localparam int CW = AW + 1;
    localparam logic signed [W-1:0] BETA_NEG = -(W'(128));

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t state, state_nxt;
    logic [CW-1:0] count;
    logic [2*W-1:0] mem [K_MAX];

    logic clear;
    logic wr_en;
    logic fill_full;
    logic pop_last;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic signed [W-1:0] g1, g2;
    logic signed [W-1:0] beta_q   [8];
    logic signed [W-1:0] beta_raw [8];
    logic signed [W-1:0] beta_nrm [8];
    logic signed [W-1:0] beta_o   [8];

    function automatic logic signed [W-1:0] max2(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
        return (a >= b) ? a : b;
    endfunction

    assign clear     = rst || (fsm_state == 2'b00);
    assign fill_full = (state == FILL) && (count == CW'(K_MAX - 1));
    assign pop_last  = (state == RUN) && (count == CW'(1));
    assign wr_idx    = (state == IDLE) ? '0 : count[AW-1:0];
    assign rd_idx    = AW'(count - CW'(1));
    assign g1        = signed'(mem[rd_idx][2*W-1:W]);
    assign g2        = signed'(mem[rd_idx][W-1:0]);

    // State register
    always_ff @(posedge clk) begin
        if (clear) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (valid_branch) state_nxt = last_branch ? RUN : FILL;
            FILL: if (valid_branch && (last_branch || fill_full)) state_nxt = RUN;
            RUN:  if (pop_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        busy  = (state != IDLE);
        wr_en = valid_branch && ((state == IDLE) || (state == FILL));
    end

    // count is the write pointer while filling and a down-counter while popping
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (wr_en) begin
            count <= (state == IDLE) ? CW'(1) : count + CW'(1);
        end else if (state == RUN) begin
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= {init_branch1, init_branch2};
    end

    always_comb begin
        beta_raw[0] = max2(beta_q[0] + g1, beta_q[4] - g1);
        beta_raw[1] = max2(beta_q[0] - g1, beta_q[4] + g1);
        beta_raw[2] = max2(beta_q[1] - g2, beta_q[5] + g2);
        beta_raw[3] = max2(beta_q[1] + g2, beta_q[5] - g2);
        beta_raw[4] = max2(beta_q[2] + g2, beta_q[6] - g2);
        beta_raw[5] = max2(beta_q[2] - g2, beta_q[6] + g2);
        beta_raw[6] = max2(beta_q[3] - g1, beta_q[7] + g1);
        beta_raw[7] = max2(beta_q[3] + g1, beta_q[7] - g1);
        for (int i = 0; i < 8; i++) beta_nrm[i] = beta_raw[i] - beta_raw[0];
    end

    // Outside RUN the recursion register sits at the terminated-trellis init
    always_ff @(posedge clk) begin
        if (clear || state != RUN) begin
            beta_q[0] <= '0;
            for (int i = 1; i < 8; i++) beta_q[i] <= BETA_NEG;
        end else begin
            for (int i = 0; i < 8; i++) beta_q[i] <= beta_nrm[i];
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            beta_o[0]   <= '0;
            for (int i = 1; i < 8; i++) beta_o[i] <= BETA_NEG;
            branch1_out <= '0;
            branch2_out <= '0;
            valid_beta  <= 1'b0;
            last_beta   <= 1'b0;
        end else if (state == RUN) begin
            for (int i = 0; i < 8; i++) beta_o[i] <= beta_q[i];
            branch1_out <= g1;
            branch2_out <= g2;
            valid_beta  <= 1'b1;
            last_beta   <= pop_last;
        end else begin
            valid_beta  <= 1'b0;
            last_beta   <= 1'b0;
        end
    end

    assign beta_0 = beta_o[0];
    assign beta_1 = beta_o[1];
    assign beta_2 = beta_o[2];
    assign beta_3 = beta_o[3];
    assign beta_4 = beta_o[4];
    assign beta_5 = beta_o[5];
    assign beta_6 = beta_o[6];
    assign beta_7 = beta_o[7];

endmodule

// File: doc/beta_window.md
# beta_window

Backward state-metric unit of the max-log-MAP SISO decoder for the 8-state constituent trellis, the reverse-direction counterpart of the forward (alpha) recursion. It buffers a block of branch-metric pairs in trellis order, then replays them last-to-first through the beta recursion. For each trellis step k it emits the successor metric beta(k+1), normalised, together with that step's branch metrics, so the LLR stage sees beta aligned with alpha(k) and gamma(k).

## Interface
- K_MAX, 64, buffer depth and maximum block length (power of two, ≥ 2)
- W, 16, metric and branch width, two's complement
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- fsm_state  in  2  decoder phase; 2'b00 clears the block exactly like rst
- valid_branch  in  1  branch pair valid, accepted only when busy=0 or state FILL
- last_branch  in  1  qualifies valid_branch: final step of the block
- init_branch1  in  W  branch metric g1 for step k
- init_branch2  in  W  branch metric g2 for step k
- beta_0 … beta_7  out  W each  normalised beta(k+1), registered
- branch1_out, branch2_out  out  W  g1/g2 of step k, registered, aligned with betas
- valid_beta  out  1  outputs valid this cycle
- last_beta  out  1  marks step k=0, the final output of the block
- busy  out  1  state ≠ IDLE, combinational from state

## Operation
- States: IDLE, FILL, RUN.
- IDLE: valid_branch writes the pair to entry 0 and sets the count to 1. Next state is FILL, or RUN if last_branch is set.
- FILL: each valid_branch writes the pair to entry count and increments count. Go to RUN when last_branch is set or when the write hits entry K_MAX-1 (forced last). Cycles without valid_branch hold state.
- RUN: one pop per cycle, no stalls, from entry count-1 down to 0. valid_branch during RUN is ignored: no write, no state effect.
- Beta register at RUN entry holds the terminated-trellis init: b0=0, b1…b7=-128.
- Each RUN cycle:
  - Output registers load the current beta register and the popped g1/g2.
  - The beta register updates with primes denoting the current register:
    - b0=max(b0'+g1, b4'-g1)
    - b1=max(b0'-g1, b4'+g1)
    - b2=max(b1'-g2, b5'+g2)
    - b3=max(b1'+g2, b5'-g2)
    - b4=max(b2'+g2, b6'-g2)
    - b5=max(b2'-g2, b6'+g2)
    - b6=max(b3'-g1, b7'+g1)
    - b7=max(b3'+g1, b7'-g1)
  - Then b0 is subtracted from all eight new values (normalisation), so the stored b0 is always 0.
- Arithmetic: W-bit signed, wrap-around, signed comparison. Ties select the first operand. Inputs with |g| < 2^(W-4) are guaranteed not to wrap.
- After the pop of entry 0, state returns to IDLE and the count clears.
- Reset or fsm_state=00 in any state:
  - State goes to IDLE and the count to 0.
  - The beta register and beta outputs take their init values.
  - valid_beta, last_beta and branch outputs go to 0.
  - Buffer contents are don't-care.

## Timing
- Reset values: beta_0=0, beta_1…beta_7=16'hFF80 (-128), branch1_out=branch2_out=0, valid_beta=0, last_beta=0, busy=0.
- Last write at edge E0 → RUN from E0.
  - The first output (step K-1, init betas) is registered at E1.
  - The K-th output (step 0) is registered at edge EK with last_beta=1.
- valid_beta is high for exactly K consecutive cycles per block.
- The state becomes IDLE at the edge that registers last_beta. busy is therefore 0 while last_beta is visible, and a new block's first valid_branch is accepted in that cycle.
- K=1: IDLE accepts valid+last, and one output follows with init betas and last_beta=1.
- Throughput: block of K costs K fill cycles plus K run cycles.

## Test plan
- Reset, then K=1 with g1=10, g2=0 → one cycle: valid_beta=1, last_beta=1, betas (0,-128×7), branch1_out=10.
- K=3, all g=0 → three consecutive outputs:
  - (0,-128×7)
  - (0,0,-128×6)
  - (0,0,0,0,-128×4), with last_beta on the third
- K=2, e0=(10,0), e1=(5,0) → first output: init betas, g1=5. Second output: (0,-10,-133,-133,-133,-133,-128,-128), g1=10, last_beta=1.
- K_MAX writes with last_branch never set → forced RUN, exactly K_MAX outputs, last_beta on the K_MAX-th; valid_branch pulses during RUN are dropped.
- rst mid-RUN, and separately fsm_state=00 mid-FILL → next cycle IDLE, busy=0, valid_beta=0, betas at init. A following K=1 block behaves as in scenario 1.
- Back-to-back blocks: first valid_branch of block 2 in the last_beta cycle of block 1 → accepted; block 2's outputs are correct and start K2 cycles after its last write.
